// File: rtl/fpu_pkg.sv
// Shared FPU definitions: comparison op codes and small helpers on binary32 fields.
package fpu_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_e;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  // True for +0 and -0; the sign bit is deliberately not part of the argument.
  function automatic logic is_zero(input logic [30:0] mag);
    return mag == 31'd0;
  endfunction

endpackage

// File: rtl/flt.sv
// Combinational binary32 less-than for finite operands; denormals order by value, +0 == -0.
module flt
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  // Sign-magnitude ordering: a negative magnitude compare is reversed.
  always_comb begin
    if (is_zero(a[30:0]) && is_zero(b[30:0])) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      lt = a[31];
    end else if (a[31]) begin
      lt = a[30:0] > b[30:0];
    end else begin
      lt = a[30:0] < b[30:0];
    end
  end

endmodule

// File: rtl/fcmp_stage.sv
// Two-stage floating-point compare/min/max unit with valid/ready handshakes and flush.
module fcmp_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x1;
  logic [31:0]      s1_x2;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic        s1_ready;
  logic        s2_ready;
  logic        lt;
  logic        eq;
  logic        both_zero;
  logic        mixed_zero;
  logic [31:0] result;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  flt u_flt (
    .a (s1_x1),
    .b (s1_x2),
    .lt(lt)
  );

  // Zeros of opposite sign are equal in value but min/max must still pick a sign.
  always_comb begin
    both_zero  = is_zero(s1_x1[30:0]) && is_zero(s1_x2[30:0]);
    mixed_zero = both_zero && (s1_x1[31] != s1_x2[31]);
    eq         = (s1_x1 == s1_x2) || both_zero;
    result     = 32'h0;
    case (s1_op)
      FEQ:     result = {31'b0, eq};
      FLT:     result = {31'b0, lt};
      FLE:     result = {31'b0, lt || eq};
      FMIN:    result = mixed_zero ? NEG_ZERO : (lt ? s1_x1 : s1_x2);
      FMAX:    result = mixed_zero ? POS_ZERO : (lt ? s1_x2 : s1_x1);
      default: result = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= 3'd0;
      s1_x1    <= 32'h0;
      s1_x2    <= 32'h0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      out_data <= 32'h0;
      out_tag  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // Result registers only load real results so they hold while out_valid is low.
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= result;
          out_tag  <= s1_tag;
        end
      end
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= in_op;
          s1_x1  <= in_x1;
          s1_x2  <= in_x2;
          s1_tag <= in_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcmp_stage.sv
// Self-checking bench for fcmp_stage: directed corner cases plus randomized traffic against a real-valued model.
module tb_fcmp_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_x1;
  logic [31:0] in_x2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int total = 0;
  int bad   = 0;

  fcmp_stage #(.TAG_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_x1    (in_x1),
    .in_x2    (in_x2),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  // Exact real value of a finite binary32 pattern.
  function automatic real to_real(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    if (e == 0) begin
      m = real'(int'(v[22:0]));
      e = 1;
    end else begin
      m = real'(int'(v[22:0])) + 8388608.0;
    end
    m = m * (2.0 ** real'(e - 150));
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] x1,
                                             input logic [31:0] x2);
    real a;
    real b;
    logic lt;
    logic eq;
    logic zpair;
    a = to_real(x1);
    b = to_real(x2);
    lt = a < b;
    eq = a == b;
    zpair = (a == 0.0) && (b == 0.0) && (x1 != x2);
    case (op)
      3'd0:    return {31'b0, eq};
      3'd1:    return {31'b0, lt};
      3'd2:    return {31'b0, lt || eq};
      3'd3:    return zpair ? 32'h8000_0000 : (lt ? x1 : x2);
      3'd4:    return zpair ? 32'h0000_0000 : (lt ? x2 : x1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int r;
    r = $urandom_range(0, 9);
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(0, 254));
    v[22:0]  = 23'($urandom);
    if (r == 0) v[30:0] = 31'd0;
    else if (r == 1) v[30:23] = 8'd0;
    else if (r == 2) v[30:23] = 8'($urandom_range(125, 128));
    return v;
  endfunction

  function automatic logic [31:0] rand_partner(input logic [31:0] x1);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return x1;
    if (r == 1) return x1 ^ 32'h8000_0000;
    return rand_fp();
  endfunction

  task automatic quiet_inputs();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_x1    = 32'h0;
    in_x2    = 32'h0;
    in_tag   = 5'd0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("[TB] FAIL reset_out_tag: got %h expected 00", out_tag); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [9];
    logic [31:0] xa  [9];
    logic [31:0] xb  [9];
    logic [31:0] ev  [9];
    ops[0] = 3'd1; xa[0] = 32'h3F80_0000; xb[0] = 32'h4000_0000; ev[0] = 32'h1;
    ops[1] = 3'd0; xa[1] = 32'h8000_0000; xb[1] = 32'h0000_0000; ev[1] = 32'h1;
    ops[2] = 3'd1; xa[2] = 32'h8000_0000; xb[2] = 32'h0000_0000; ev[2] = 32'h0;
    ops[3] = 3'd3; xa[3] = 32'h8000_0000; xb[3] = 32'h0000_0000; ev[3] = 32'h8000_0000;
    ops[4] = 3'd4; xa[4] = 32'h8000_0000; xb[4] = 32'h0000_0000; ev[4] = 32'h0000_0000;
    ops[5] = 3'd1; xa[5] = 32'h8000_0001; xb[5] = 32'h0000_0001; ev[5] = 32'h1;
    ops[6] = 3'd2; xa[6] = 32'h0000_0002; xb[6] = 32'h0000_0001; ev[6] = 32'h0;
    ops[7] = 3'd6; xa[7] = 32'h3F80_0000; xb[7] = 32'h4000_0000; ev[7] = 32'h0;
    ops[8] = 3'd3; xa[8] = 32'h0000_0000; xb[8] = 32'h8000_0000; ev[8] = 32'h8000_0000;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      quiet_inputs();
      in_valid = 1'b1; in_op = ops[i]; in_x1 = xa[i]; in_x2 = xb[i]; in_tag = 5'(i + 3);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_out_valid: got %b expected 1", i, out_valid); end
      total++; if (out_data !== ev[i]) begin bad++; $display("[TB] FAIL dir%0d_data: got %h expected %h", i, out_data, ev[i]); end
      total++; if (out_tag !== 5'(i + 3)) begin bad++; $display("[TB] FAIL dir%0d_tag: got %0d expected %0d", i, out_tag, i + 3); end
    end
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir_drain_valid: got %b expected 0", out_valid); end
    total++; if (out_data !== ev[8]) begin bad++; $display("[TB] FAIL dir_hold_data: got %h expected %h", out_data, ev[8]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    logic [31:0] ed [3];
    int idx;
    int got;
    for (int i = 0; i < 3; i++) begin
      xa[i] = rand_fp();
      xb[i] = rand_partner(xa[i]);
      ed[i] = ref_result(3'd1, xa[i], xb[i]);
    end
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      quiet_inputs();
      in_valid = idx < 3;
      in_op = 3'd1;
      if (idx < 3) begin
        in_x1 = xa[idx]; in_x2 = xb[idx]; in_tag = 5'(idx + 1);
      end
      out_ready = cyc >= 4;
      #1;
      if (cyc == 2 || cyc == 3) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall_in_ready c%0d: got %b expected 0", cyc, in_ready); end
        total++; if (idx !== 2) begin bad++; $display("[TB] FAIL b2b_accepts c%0d: got %0d expected 2", cyc, idx); end
        total++; if (out_valid !== 1'b1 || out_tag !== 5'd1) begin bad++; $display("[TB] FAIL b2b_stall_hold c%0d: got valid=%b tag=%0d expected valid=1 tag=1", cyc, out_valid, out_tag); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_tag !== 5'(got + 1) || out_data !== ed[got]) begin
          bad++; $display("[TB] FAIL b2b_result%0d: got tag=%0d data=%h expected tag=%0d data=%h", got, out_tag, out_data, got + 1, ed[got]);
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    total++; if (got !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 3", got); end
    @(negedge clk);
    quiet_inputs();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    int ghosts;
    int got;
    logic [31:0] fa;
    logic [31:0] fb;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      quiet_inputs();
      in_valid = 1'b1; in_op = 3'd4; in_x1 = rand_fp(); in_x2 = rand_fp(); in_tag = 5'(10 + cyc);
      out_ready = cyc == 2;
      flush = cyc == 2;
      #1;
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_offer_ready: got %b expected 1", in_ready); end
      end
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
    ghosts = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid) ghosts++;
    end
    total++; if (ghosts !== 0) begin bad++; $display("[TB] FAIL flush_ghosts: got %0d expected 0", ghosts); end
    fa = rand_fp();
    fb = rand_partner(fa);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd2; in_x1 = fa; in_x2 = fb; in_tag = 5'd13;
    got = 0;
    for (int cyc = 0; cyc < 6 && got == 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        got = 1;
        total++;
        if (out_tag !== 5'd13 || out_data !== ref_result(3'd2, fa, fb)) begin
          bad++; $display("[TB] FAIL flush_next: got tag=%0d data=%h expected tag=13 data=%h", out_tag, out_data, ref_result(3'd2, fa, fb));
        end
      end
    end
    total++; if (got !== 1) begin bad++; $display("[TB] FAIL flush_next_timeout: got %0d results expected 1", got); end
  endtask

  task automatic test_reset_midflight();
    int ghosts;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      quiet_inputs();
      in_valid = 1'b1; in_op = 3'd4; in_x1 = 32'h3F80_0000; in_x2 = 32'h4000_0000; in_tag = 5'(20 + cyc);
      out_ready = 1'b0;
    end
    @(negedge clk);
    quiet_inputs();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_tag = 5'd22; out_ready = 1'b1;
    @(negedge clk);
    quiet_inputs();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_out_data: got %h expected 00000000", out_data); end
    ghosts = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid) ghosts++;
    end
    total++; if (ghosts !== 0) begin bad++; $display("[TB] FAIL rstmid_ghosts: got %0d expected 0", ghosts); end
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_x1 = 32'hC000_0000; in_x2 = 32'hBF80_0000; in_tag = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hBF80_0000 || out_tag !== 5'd7) begin
      bad++; $display("[TB] FAIL rstmid_fmax: got valid=%b data=%h tag=%0d expected valid=1 data=bf800000 tag=7", out_valid, out_data, out_tag);
    end
  endtask

  task automatic test_random();
    int          q_acc [$];
    logic [31:0] q_data[$];
    logic [4:0]  q_tag [$];
    logic [31:0] last_d;
    logic [4:0]  last_t;
    logic        exp_ov;
    logic        exp_ir;
    int          errs_before;
    @(negedge clk);
    quiet_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_d = 32'h0;
    last_t = 5'd0;
    errs_before = bad;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid  = $urandom_range(0, 9) < 7;
      in_op     = 3'($urandom_range(0, 7));
      in_x1     = rand_fp();
      in_x2     = rand_partner(in_x1);
      in_tag    = 5'($urandom);
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 39) == 0;
      #1;
      exp_ov = (q_acc.size() > 0) && (cyc >= q_acc[0] + 2);
      exp_ir = (q_acc.size() < 2) || out_ready;
      total++; if (out_valid !== exp_ov) begin bad++; $display("[TB] FAIL rnd_out_valid c%0d: got %b expected %b", cyc, out_valid, exp_ov); end
      total++; if (in_ready !== exp_ir) begin bad++; $display("[TB] FAIL rnd_in_ready c%0d: got %b expected %b", cyc, in_ready, exp_ir); end
      if (exp_ov) begin
        total++;
        if (out_data !== q_data[0] || out_tag !== q_tag[0]) begin
          bad++; $display("[TB] FAIL rnd_result c%0d: got data=%h tag=%0d expected data=%h tag=%0d", cyc, out_data, out_tag, q_data[0], q_tag[0]);
        end
        last_d = q_data[0];
        last_t = q_tag[0];
      end else begin
        total++;
        if (out_data !== last_d || out_tag !== last_t) begin
          bad++; $display("[TB] FAIL rnd_hold c%0d: got data=%h tag=%0d expected data=%h tag=%0d", cyc, out_data, out_tag, last_d, last_t);
        end
      end
      if (flush) begin
        q_acc.delete(); q_data.delete(); q_tag.delete();
      end else begin
        if (exp_ov && out_ready) begin
          void'(q_acc.pop_front()); void'(q_data.pop_front()); void'(q_tag.pop_front());
        end
        if (in_valid && exp_ir) begin
          q_acc.push_back(cyc);
          q_data.push_back(ref_result(in_op, in_x1, in_x2));
          q_tag.push_back(in_tag);
        end
      end
      if (bad - errs_before > 20) begin
        $display("[TB] too many random errors, stopping random phase");
        break;
      end
    end
    @(negedge clk);
    quiet_inputs();
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcmp_stage.md
FCMP_STAGE -- requirements
Module: fcmp_stage

Interface
REQ-001 Parameter TAG_W, default 5, width of the destination-register tag carried with each request.
REQ-002 Port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port flush  input  1  synchronous pipeline kill, active-high.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  stage can accept the request this cycle.
REQ-007 Port in_op  input  3  operation code: FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4, codes 5-7 reserved.
REQ-008 Port in_x1  input  32  operand 1, IEEE-754 binary32.
REQ-009 Port in_x2  input  32  operand 2, IEEE-754 binary32.
REQ-010 Port in_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 Port out_data  output  32  result word.
REQ-014 Port out_tag  output  TAG_W  tag of the result.

Function
REQ-015 A request is accepted on a cycle with in_valid=1, in_ready=1 and flush=0.
REQ-016 A result is consumed on a cycle with out_valid=1 and out_ready=1.
REQ-017 Pipeline: S1 operand register, then S2 result register; the result of a request accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready is not held low.
REQ-018 S2 advance condition: s2_ready = !s2_valid | out_ready.
REQ-019 S1 advance condition: s1_ready = !s1_valid | s2_ready.
REQ-020 in_ready = s1_ready; throughput is one request per cycle when out_ready is held at 1.
REQ-021 Backpressure: with out_ready=0, S1 and S2 hold their contents and values unchanged, at most 2 requests are in flight, and results leave in acceptance order.
REQ-022 Ordering: lt = x1<x2 and eq = x1==x2 as real values; denormals compare by value; +0 and -0 compare equal.
REQ-023 FEQ returns {31'b0,eq}; FLT returns {31'b0,lt}; FLE returns {31'b0,lt|eq}.
REQ-024 FMIN returns x1 if lt, else x2; FMAX returns x2 if lt, else x1.
REQ-025 On FMIN of a signed-zero pair (+0,-0 in either order), -0 (0x80000000) is returned; on FMAX of such a pair, +0 (0x00000000) is returned.
REQ-026 Reserved op codes return 32'h0 with their tag and follow the normal latency.
REQ-027 Operands with exponent field 255 (Inf/NaN) are outside the supported domain; out_data is unspecified for them, handshake and tag remain correct, and no exception is raised.
REQ-028 Flush=1 at an edge clears s1_valid and s2_valid; a request offered in that cycle is dropped.
REQ-029 Flush overrides a simultaneous acceptance and a simultaneous consumption.
REQ-030 out_data and out_tag hold their last values while out_valid=0.

Reset
REQ-031 With rst=1 at an edge, s1_valid=0 and s2_valid=0, so out_valid=0 and in_ready=1 from the next cycle.
REQ-032 After the reset edge, out_data=32'h0 and out_tag=0.
REQ-033 Reset has priority over flush and the handshakes.
REQ-034 Reset asserted mid-operation discards all in-flight requests; none of them is ever presented afterwards.

Structure
REQ-035 The op-code enum (FEQ..FMAX) belongs in the shared FPU package, fpu_pkg, which fcmp_stage imports.
REQ-036 The existing combinational less-than comparator flt is instantiated once as the sole sub-module and drives lt from the S1 registers.
REQ-037 eq and the signed-zero handling are computed locally between S1 and S2.

Verification
REQ-038 FLT with x1=0x3F800000, x2=0x40000000, out_ready=1 -> out_data=1 one cycle after acceptance, tag preserved.
REQ-039 FEQ with x1=0x80000000, x2=0x00000000 -> out_data=1; FLT on the same pair -> 0; FMIN -> 0x80000000; FMAX -> 0x00000000.
REQ-040 FLT with x1=0x80000001, x2=0x00000001 (denormals) -> out_data=1; FLE with x1=0x00000002, x2=0x00000001 -> out_data=0.
REQ-041 Three back-to-back requests with tags 1,2,3 and out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts; after out_ready rises, tags come out 1,2,3 with no loss or duplication.
REQ-042 Flush pulsed with 2 requests in flight and a third request offered -> out_valid=0 next cycle, none of the 3 results ever appears.
REQ-043 rst asserted with S1 and S2 both full -> out_valid=0, in_ready=1, out_data=0 after the edge; a subsequent FMAX of 0xC0000000 and 0xBF800000 -> 0xBF800000.
